// File: rtl/mesh_term_tx_if.sv
// Terminal-side write port and mesh-side pop port of mesh_term_tx, bundled as one interface.
interface mesh_term_tx_if #(
    parameter int unsigned pckg_sz    = 40,
    parameter int unsigned fifo_depth = 4
) ();
    localparam int unsigned pay_w = pckg_sz - 17;
    localparam int unsigned cnt_w = $clog2(fifo_depth + 1);

    // Terminal agent write side
    logic             wr_en;
    logic [3:0]       wr_row;
    logic [3:0]       wr_col;
    logic             wr_mode;
    logic             wr_bcast;
    logic [pay_w-1:0] wr_payload;
    logic             full;
    logic [cnt_w-1:0] count;
    logic [15:0]      drop_cnt;

    // Mesh external-port side
    logic               pndng_i_in;
    logic [pckg_sz-1:0] data_out_i_in;
    logic               popin;

    modport master (
        output wr_en, wr_row, wr_col, wr_mode, wr_bcast, wr_payload, popin,
        input  full, count, drop_cnt, pndng_i_in, data_out_i_in
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_mode, wr_bcast, wr_payload, popin,
        output full, count, drop_cnt, pndng_i_in, data_out_i_in
    );
endinterface

// File: rtl/mesh_term_tx.sv
// Per-terminal mesh transmit queue: assembles packets and buffers them in a FWFT FIFO.
// Optional dropped-write counter enabled by defining MESH_TX_DROP_CNT_EN.
module mesh_term_tx #(
    parameter int unsigned pckg_sz    = 40,
    parameter int unsigned fifo_depth = 4,
    parameter logic [7:0]  bdcst      = 8'hFF,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned COLUMS     = 2
) (
    input  logic           clk,
    input  logic           reset,
    mesh_term_tx_if.slave  tx
);
    localparam int unsigned pay_w = pckg_sz - 17;
    localparam int unsigned cnt_w = $clog2(fifo_depth + 1);
    localparam int unsigned ptr_w = $clog2(fifo_depth);

    if (pckg_sz < 24 || fifo_depth < 2 || ROWS < 1 || COLUMS < 1) begin : g_cfg_check
        $error("mesh_term_tx: unsupported parameter set");
    end

    typedef struct packed {
        logic [7:0]       next_jump;
        logic [3:0]       row;
        logic [3:0]       col;
        logic             mode;
        logic [pay_w-1:0] payload;
    } pkt_t;

    logic [pckg_sz-1:0] mem [fifo_depth];

    logic [ptr_w-1:0]   rd_ptr;
    logic [ptr_w-1:0]   wr_ptr;
    logic [cnt_w-1:0]   cnt;
    logic               full_q;
    logic               pndng_q;
    logic [pckg_sz-1:0] head_q;

    logic [ptr_w-1:0]   rd_ptr_nxt;
    logic [ptr_w-1:0]   wr_ptr_nxt;
    logic [cnt_w-1:0]   cnt_nxt;
    logic [pckg_sz-1:0] head_nxt;
    logic               pop_c;
    logic               push_c;
    pkt_t               pkt_c;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(fifo_depth - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    // Packet assembly from the write-side fields
    always_comb begin
        pkt_c.next_jump = tx.wr_bcast ? bdcst : 8'h00;
        pkt_c.row       = tx.wr_row;
        pkt_c.col       = tx.wr_col;
        pkt_c.mode      = tx.wr_mode;
        pkt_c.payload   = tx.wr_payload;
    end

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign pop_c  = tx.popin && pndng_q;
    assign push_c = tx.wr_en && (!full_q || pop_c);

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        cnt_nxt    = cnt;
        head_nxt   = '0;

        if (pop_c)  rd_ptr_nxt = ptr_inc(rd_ptr);
        if (push_c) wr_ptr_nxt = ptr_inc(wr_ptr);

        case ({push_c, pop_c})
            2'b10:   cnt_nxt = cnt + cnt_w'(1);
            2'b01:   cnt_nxt = cnt - cnt_w'(1);
            default: cnt_nxt = cnt;
        endcase

        // Head register is loaded with whatever sits at the next read pointer,
        // taking the incoming packet when it lands exactly there.
        if (cnt_nxt != '0) begin
            if (push_c && (wr_ptr == rd_ptr_nxt)) head_nxt = pkt_c;
            else                                  head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            pndng_q <= 1'b0;
            head_q  <= '0;
        end else begin
            rd_ptr  <= rd_ptr_nxt;
            wr_ptr  <= wr_ptr_nxt;
            cnt     <= cnt_nxt;
            full_q  <= (cnt_nxt == cnt_w'(fifo_depth));
            pndng_q <= (cnt_nxt != '0);
            head_q  <= head_nxt;
        end
    end

    // Storage is deliberately left uninitialised by reset
    always_ff @(posedge clk) begin
        if (!reset && push_c) mem[wr_ptr] <= pkt_c;
    end

`ifdef MESH_TX_DROP_CNT_EN
    logic        drop_c;
    logic [15:0] drop_q;

    assign drop_c = tx.wr_en && full_q && !pop_c;

    always_ff @(posedge clk) begin
        if (reset)                             drop_q <= 16'h0000;
        else if (drop_c && drop_q != 16'hFFFF) drop_q <= drop_q + 16'h0001;
    end

    assign tx.drop_cnt = drop_q;
`else
    assign tx.drop_cnt = 16'h0000;
`endif

    assign tx.full          = full_q;
    assign tx.count         = cnt;
    assign tx.pndng_i_in    = pndng_q;
    assign tx.data_out_i_in = head_q;
endmodule

// File: tb/tb_mesh_term_tx.sv
// Randomised self-checking bench for mesh_term_tx against a queue-based reference model.
module tb_mesh_term_tx;
    localparam int unsigned PSZ   = 40;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mesh_term_tx_if #(.pckg_sz(PSZ), .fifo_depth(DEPTH)) tif ();

    mesh_term_tx #(.pckg_sz(PSZ), .fifo_depth(DEPTH), .bdcst(8'hFF), .ROWS(2), .COLUMS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .tx    (tif)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    logic [PSZ-1:0] model_q[$];
    int             model_drops = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_drops();
`ifdef MESH_TX_DROP_CNT_EN
        return 16'(model_drops);
`else
        return 16'h0000;
`endif
    endfunction

    // Reference model: one queue, spec rules applied to pre-edge inputs
    always @(posedge clk) begin
        bit pop, acc;
        logic [PSZ-1:0] pkt;
        if (reset) begin
            model_q.delete();
            model_drops = 0;
        end else begin
            pkt = {(tif.wr_bcast ? 8'hFF : 8'h00), tif.wr_row, tif.wr_col, tif.wr_mode, tif.wr_payload};
            pop = tif.popin && (model_q.size() > 0);
            acc = tif.wr_en && ((model_q.size() < DEPTH) || pop);
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back(pkt);
            else if (tif.wr_en && model_drops < 65535) model_drops++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("count", 64'(tif.count), 64'(model_q.size()));
            check("full", 64'(tif.full), 64'(model_q.size() == DEPTH));
            check("pndng", 64'(tif.pndng_i_in), 64'(model_q.size() != 0));
            check("data", 64'(tif.data_out_i_in), (model_q.size() != 0) ? 64'(model_q[0]) : 64'h0);
            check("drop_cnt", 64'(tif.drop_cnt), 64'(exp_drops()));
        end
    end

    task automatic step(input bit we, input logic [3:0] row, input logic [3:0] col, input bit mode,
                        input bit bc, input logic [22:0] pay, input bit pop, input bit rst);
        reset          = rst;
        tif.wr_en      = we;
        tif.wr_row     = row;
        tif.wr_col     = col;
        tif.wr_mode    = mode;
        tif.wr_bcast   = bc;
        tif.wr_payload = pay;
        tif.popin      = pop;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic wr(input logic [22:0] p, input bit pop); step(1, 4'h3, 4'h4, 0, 0, p, pop, 0); endtask

    initial begin
        logic [15:0] d0;
        // Reset for 5 cycles
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        idle();
        check("rst_pndng", 64'(tif.pndng_i_in), 64'h0);
        check("rst_data", 64'(tif.data_out_i_in), 64'h0);
        check("rst_full", 64'(tif.full), 64'h0);
        check("rst_count", 64'(tif.count), 64'h0);
        check("rst_drop", 64'(tif.drop_cnt), 64'h0);

        // Single packet, field placement
        step(1, 4'h2, 4'h1, 1, 0, 23'h155AA5, 0, 0);
        check("pkt_data", 64'(tif.data_out_i_in), 64'h00_2_1_955AA5);
        check("pkt_pndng", 64'(tif.pndng_i_in), 64'h1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("pop_pndng", 64'(tif.pndng_i_in), 64'h0);

        // Fill, overflow, write+pop at full, drain in order
        for (int i = 1; i <= 4; i++) wr(23'(i), 0);
        check("fill_full", 64'(tif.full), 64'h1);
        check("fill_count", 64'(tif.count), 64'h4);
        wr(23'h5A, 0);
        check("ovf_count", 64'(tif.count), 64'h4);
`ifdef MESH_TX_DROP_CNT_EN
        check("ovf_drop", 64'(tif.drop_cnt), 64'h1);
`else
        check("ovf_drop", 64'(tif.drop_cnt), 64'h0);
`endif
        d0 = exp_drops();
        check("ovf_head", 64'(tif.data_out_i_in), 64'h00_3_4_000001);
        wr(23'h5, 1);
        check("wp_count", 64'(tif.count), 64'h4);
        check("wp_head", 64'(tif.data_out_i_in), 64'h00_3_4_000002);
        check("wp_drop", 64'(tif.drop_cnt), 64'(d0));
        for (int i = 2; i <= 5; i++) begin
            check("drain_head", 64'(tif.data_out_i_in), 64'h00_3_4_000000 + 64'(i));
            step(0, 0, 0, 0, 0, 0, 1, 0);
        end
        check("drain_pndng", 64'(tif.pndng_i_in), 64'h0);

        // Broadcast, then popin while empty
        step(1, 4'h1, 4'h0, 0, 1, 23'h7, 0, 0);
        check("bcast_nj", 64'(tif.data_out_i_in[39:32]), 64'hFF);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 0);
            check("empty_pop_count", 64'(tif.count), 64'h0);
        end

        // Mid-operation reset
        for (int i = 0; i < 3; i++) wr(23'(16 + i), 0);
        step(1, 4'h3, 4'h4, 0, 0, 23'h99, 1, 1);
        check("mrst_count", 64'(tif.count), 64'h0);
        check("mrst_pndng", 64'(tif.pndng_i_in), 64'h0);
        wr(23'h42, 0);
        check("post_rst_data", 64'(tif.data_out_i_in), 64'h00_3_4_000042);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            step(($urandom_range(0, 99) < 60), 4'($urandom), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) == 0), 23'($urandom),
                 ($urandom_range(0, 99) < ((n / 500) % 2 ? 30 : 65)),
                 ($urandom_range(0, 299) == 0));
        end
        idle();
        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mesh_term_tx.md
# mesh_term_tx

Per-terminal transmit queue that sits directly upstream of a `mesh_gnrtr` external port. It accepts packet fields from a terminal agent and assembles them into `pckg_sz`-bit mesh packets. It buffers the packets in a first-word-fall-through FIFO and presents them to the mesh on the `pndng_i_in` / `data_out_i_in` / `popin` handshake. One instance is placed per mesh terminal.

## Interface
- `pckg_sz`, 40: packet width in bits; must be ≥ 24.
- `fifo_depth`, 4: packet capacity; must be ≥ 2.
- `bdcst`, 8'hFF: value placed in the next-jump field for broadcast packets.
- `ROWS`, 2: mesh rows; carried for consistency with the mesh, not checked.
- `COLUMS`, 2: mesh columns; carried for consistency with the mesh, not checked.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: write strobe for one packet.
- `wr_row` in 4: destination row.
- `wr_col` in 4: destination column.
- `wr_mode` in 1: routing mode bit (0 = column first, 1 = row first).
- `wr_bcast` in 1: broadcast packet.
- `wr_payload` in `pckg_sz-17`: payload.
- `full` out 1: FIFO holds `fifo_depth` packets.
- `count` out `$clog2(fifo_depth+1)`: current occupancy.
- `drop_cnt` out 16: count of rejected writes (see Configuration).
- `pndng_i_in` out 1: a packet is available to the mesh.
- `data_out_i_in` out `pckg_sz`: head packet.
- `popin` in 1: mesh consumes the head packet.

## Operation
Packet assembly happens at write time:
- `[pckg_sz-1 : pckg_sz-8]` = `bdcst` if `wr_bcast`, else 8'h00.
- `[pckg_sz-9 : pckg_sz-12]` = `wr_row`.
- `[pckg_sz-13 : pckg_sz-16]` = `wr_col`.
- `[pckg_sz-17]` = `wr_mode`.
- `[pckg_sz-18 : 0]` = `wr_payload`.

FIFO structure:
- Circular buffer with read pointer, write pointer and `count`.
- Pointers wrap from `fifo_depth-1` to 0; `fifo_depth` need not be a power of two.

Accept and pop rules:
- A write is accepted when `wr_en` is high and either (`count < fifo_depth`) or (`popin` && `pndng_i_in`).
- A pop occurs when `popin` is high and `pndng_i_in` is high.
- `popin` while empty is ignored: no pointer change, no error.
- A write and a pop in the same cycle leave `count` unchanged; both pointers advance.
- A write with `full` = 1 and no pop is dropped. FIFO contents are unchanged.

Outputs:
- `pndng_i_in` = (`count != 0`).
- `data_out_i_in` = buffer[rd_ptr] when `pndng_i_in` is high, else all zeros.
- `full` = (`count == fifo_depth`).

## Timing
- Reset state: `count` = 0, pointers = 0, `pndng_i_in` = 0, `data_out_i_in` = 0, `full` = 0, `drop_cnt` = 0. Buffer storage is not cleared.
- Reset asserted mid-operation discards all queued packets on the next edge. Inputs sampled in that cycle are ignored.
- Write latency: a write accepted at edge N into an empty FIFO gives `pndng_i_in` = 1 with the assembled packet on `data_out_i_in` after edge N. There is no bypass in the same cycle.
- Pop: `popin` sampled high at edge N presents the next packet, or deasserts `pndng_i_in`, after edge N.
- The mesh may hold `popin` high on consecutive cycles; one packet is popped per cycle.
- `full`, `count` and `pndng_i_in` are pure functions of registered state; none depends combinationally on `wr_en` or `popin`.

## Configuration
- Macro: `MESH_TX_DROP_CNT_EN`.
- Defined: `drop_cnt` increments on every dropped write and saturates at 16'hFFFF. It clears on reset.
- Not defined: no counter logic is built and `drop_cnt` is tied to 16'h0000.
- All other behaviour is identical in both configurations.

## Test plan
- Reset for 5 cycles, then idle: `pndng_i_in` = 0, `data_out_i_in` = 0, `full` = 0, `count` = 0, `drop_cnt` = 0.
- `pckg_sz` = 40. Write row = 2, col = 1, mode = 1, bcast = 0, payload = 23'h155AA5. Next cycle `data_out_i_in` = 40'h00_2_1_955AA5 (next-jump 00, row 2, col 1, mode bit 1, payload 155AA5) and `pndng_i_in` = 1. Pop one cycle later: `pndng_i_in` = 0.
- Write 4 packets with no pop: `full` = 1 and `count` = 4. A 5th write is dropped: `count` stays 4 and, with the macro defined, `drop_cnt` = 1. Then pop 4 times: packets come out in write order and `pndng_i_in` = 0 after the 4th pop.
- With `full` = 1, assert write and `popin` in the same cycle: the write is accepted, `count` stays 4, the head advances, and `drop_cnt` is unchanged.
- Broadcast write (`wr_bcast` = 1): `data_out_i_in[39:32]` = 8'hFF. Then assert `popin` while empty for 3 cycles: no state change.
- Load 3 packets and assert `reset` for one cycle: `count` = 0 and `pndng_i_in` = 0 on the next cycle. A subsequent write appears normally.
